// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: widths, select codes and FSM encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned CNT_W     = 4;
  localparam logic [2:0]  SEL_SLT   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between a requester and the ALU command sequencer.
interface alu_cmd_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_sel;
  logic             cmd_ci;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_flag;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_ci, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flag
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_ci, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flag
  );

endinterface

// File: rtl/alu_cmd_sequencer_alu.sv
// Combinational 32-bit ALU: arithmetic on selects 000-100 (100 is compare/subtract), logic on 101-111.
module alu_32_bit
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic                 S0,
  input  logic                 S1,
  input  logic                 S2,
  input  logic                 Ci,
  output logic [ALU_WIDTH-1:0] F,
  output logic                 Co
);

  logic [2:0]           sel;
  logic [ALU_WIDTH:0]   sum;
  logic [ALU_WIDTH:0]   a_ext;
  logic [ALU_WIDTH:0]   ci_ext;

  assign sel    = {S2, S1, S0};
  assign a_ext  = {1'b0, a};
  assign ci_ext = (ALU_WIDTH+1)'(Ci);

  // Carry-out of the widened sum is Co; logic ops report Co=0
  always_comb begin
    sum = '0;
    unique case (sel)
      3'b000:         sum = a_ext + {1'b0, b} + ci_ext;
      3'b001, 3'b100: sum = a_ext + {1'b0, ~b} + ci_ext;
      3'b010:         sum = a_ext + ci_ext;
      3'b011:         sum = a_ext + {1'b0, {ALU_WIDTH{1'b1}}} + ci_ext;
      3'b101:         sum = {1'b0, a & b};
      3'b110:         sum = {1'b0, a | b};
      default:        sum = {1'b0, a ^ b};
    endcase
  end

  assign F  = sum[ALU_WIDTH-1:0];
  assign Co = sum[ALU_WIDTH];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Clocked valid/ready front-end for alu_32_bit: latch a command, let the ALU settle, return F/Co.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = ALU_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst,
  alu_cmd_if.slave bus
);

  if (WIDTH != ALU_WIDTH) begin : g_bad_width
    $error("alu_cmd_sequencer: WIDTH must equal ALU_WIDTH");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_cmd_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         sel_q, sel_d;
  logic               ci_q, ci_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_flag_q, rsp_flag_d;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_co;

  alu_32_bit u_alu (a_q, b_q, sel_q[0], sel_q[1], sel_q[2], ci_q, alu_f, alu_co);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      ci_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      ci_q        <= ci_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flag_q  <= rsp_flag_d;
    end
  end

  // Next-state and next-output logic; EXEC lasts SETTLE_CYCLES+1 clocks after the accept edge
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    ci_d        = ci_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flag_d  = rsp_flag_q;

    unique case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          sel_d   = bus.cmd_sel;
          ci_d    = bus.cmd_ci;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          rsp_valid_d = 1'b1;
          rsp_flag_d  = alu_co;
          rsp_data_d  = (sel_q == SEL_SLT && ci_q) ? WIDTH'(alu_co) : alu_f;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flag  = rsp_flag_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed scoreboard bench for alu_cmd_sequencer with settle times of 1 and 4 cycles.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic         flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  logic         which;
  logic         cv, cc, rr;
  logic [W-1:0] ca, cb;
  logic [2:0]   cs;

  alu_cmd_if #(.WIDTH(W)) bus1 ();
  alu_cmd_if #(.WIDTH(W)) bus4 ();

  assign bus1.cmd_valid = cv & ~which;
  assign bus4.cmd_valid = cv & which;
  assign bus1.rsp_ready = rr & ~which;
  assign bus4.rsp_ready = rr & which;
  assign bus1.cmd_a = ca;  assign bus4.cmd_a = ca;
  assign bus1.cmd_b = cb;  assign bus4.cmd_b = cb;
  assign bus1.cmd_sel = cs; assign bus4.cmd_sel = cs;
  assign bus1.cmd_ci = cc;  assign bus4.cmd_ci = cc;

  logic         rdy, rv, rf;
  logic [W-1:0] rd;
  assign rdy = which ? bus4.cmd_ready : bus1.cmd_ready;
  assign rv  = which ? bus4.rsp_valid : bus1.rsp_valid;
  assign rf  = which ? bus4.rsp_flag  : bus1.rsp_flag;
  assign rd  = which ? bus4.rsp_data  : bus1.rsp_data;

  alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  exp_t        sb[$];
  int unsigned acc_cyc;

  // Reference behaviour: subtract-style ops carry out when a+ci exceeds b
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] sel, input logic ci);
    exp_t         e;
    logic [W-1:0] f;
    logic         co;
    logic [W:0]   wide;
    case (sel)
      3'd0: begin wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci}; f = wide[W-1:0]; co = wide[W]; end
      3'd1, 3'd4: begin f = a - b - {{(W-1){1'b0}}, ~ci}; co = ({1'b0, a} + {{W{1'b0}}, ci}) > {1'b0, b}; end
      3'd2: begin f = a + {{(W-1){1'b0}}, ci}; co = ci && (a == {W{1'b1}}); end
      3'd3: begin f = a - {{(W-1){1'b0}}, ~ci}; co = ci || (a != '0); end
      3'd5: begin f = a & b; co = 1'b0; end
      3'd6: begin f = a | b; co = 1'b0; end
      default: begin f = a ^ b; co = 1'b0; end
    endcase
    e.flag = co;
    e.data = (sel == 3'b100 && ci) ? {{(W-1){1'b0}}, co} : f;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] s, input logic c);
    int n = 0;
    while (rdy !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_before_send", 64'(rdy), 64'd1);
    ca = a; cb = b; cs = s; cc = c; cv = 1'b1;
    @(posedge clk); #1;
    cv = 1'b0;
    acc_cyc = cyc;
    sb.push_back(model(a, b, s, c));
  endtask

  task automatic wait_rsp(input int unsigned lat);
    int n = 0;
    while (rv !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("rsp_latency", 64'(cyc - acc_cyc), 64'(lat));
  endtask

  task automatic finish_rsp();
    exp_t         e;
    logic [W-1:0] d0;
    logic         f0;
    d0 = rd; f0 = rf;
    rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    chk("rsp_valid_drop", 64'(rv), 64'd0);
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_data", 64'(d0), 64'(e.data));
      chk("rsp_flag", 64'(f0), 64'(e.flag));
    end
    chk("rsp_data_held", 64'(rd), 64'(d0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d0;
    logic         f0, stable, seen;
    exp_t         e;

    which = 1'b0; cv = 1'b1; rr = 1'b0;
    ca = '0; cb = '0; cs = '0; cc = 1'b0;
    rst = 1'b1;

    // Reset with cmd_valid held high
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 64'(rdy), 64'd1);
    chk("reset_rsp_valid", 64'(rv), 64'd0);
    chk("reset_rsp_data", 64'(rd), 64'd0);
    chk("reset_rsp_flag", 64'(rf), 64'd0);
    cv = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("no_accept_after_reset", 64'(rdy), 64'd1);
    chk("no_rsp_after_reset", 64'(rv), 64'd0);

    // SLT, B<A
    send(32'h41010101, 32'h21616161, SEL_SLT, 1'b1);
    wait_rsp(2);
    finish_rsp();

    // SLT, B>A
    send(32'h25010107, 32'h61616167, SEL_SLT, 1'b1);
    wait_rsp(2);
    finish_rsp();

    // Back-pressure with a competing command held on the port
    send(32'hDEADBEEF, 32'h12345678, 3'b000, 1'b1);
    wait_rsp(2);
    d0 = rd; f0 = rf; stable = 1'b1;
    ca = 32'h0000_0010; cb = 32'h0000_0003; cs = 3'b001; cc = 1'b1; cv = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rd !== d0 || rf !== f0 || rv !== 1'b1 || rdy !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    chk("bp_valid_drop", 64'(rv), 64'd0);
    e = sb.pop_front();
    chk("bp_rsp_data", 64'(d0), 64'(e.data));
    chk("bp_rsp_flag", 64'(f0), 64'(e.flag));
    chk("bp_ready_after_hs", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    cv = 1'b0;
    acc_cyc = cyc;
    sb.push_back(model(32'h0000_0010, 32'h0000_0003, 3'b001, 1'b1));
    chk("bp_second_accepted", 64'(rdy), 64'd0);
    wait_rsp(2);
    finish_rsp();

    // Mid-operation reset on the 4-cycle instance
    which = 1'b1;
    send(32'h0000_0005, 32'h0000_0009, SEL_SLT, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_cmd_ready", 64'(rdy), 64'd1);
    chk("midrst_rsp_data", 64'(rd), 64'd0);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (rv !== 1'b0) seen = 1'b1; end
    chk("midrst_no_rsp", 64'(seen), 64'd0);
    send(32'h8000_0000, 32'h7FFF_FFFF, SEL_SLT, 1'b1);
    wait_rsp(5);
    finish_rsp();
    send(32'h1234_5678, 32'h1234_5678, SEL_SLT, 1'b1);
    wait_rsp(5);
    finish_rsp();

    // Select sweep on the 1-cycle instance, plus carry and SLT corner cases
    which = 1'b0;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 2; c++) begin
        send($urandom, $urandom, 3'(s), 1'(c));
        wait_rsp(2);
        finish_rsp();
      end
    end
    send(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0);
    wait_rsp(2);
    finish_rsp();
    send(32'h0000_0000, 32'h0000_0000, 3'b011, 1'b0);
    wait_rsp(2);
    finish_rsp();
    send(32'hFFFF_FFFF, 32'h0000_0000, 3'b010, 1'b1);
    wait_rsp(2);
    finish_rsp();
    send(32'h0000_0007, 32'h0000_0009, SEL_SLT, 1'b0);
    wait_rsp(2);
    finish_rsp();

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
